qsys_system_pio_irq: RTL
========================

QSYS_SYSTEM_PIO_IRQ -- requirements
Module: qsys_system_pio_irq

Interface
REQ-001 SHALL provide parameter OUT_WIDTH, default 16: width of the output register, legal range 1..32.
REQ-002 SHALL provide parameter RESET_VALUE, default 64: reset value of the output register, truncated to OUT_WIDTH bits.
REQ-003 SHALL provide parameter IN_WIDTH, default 8: width of the input port, legal range 1..32.
REQ-004 SHALL provide parameter EDGE_TYPE, default 0: edge that is captured; 0 is rising, 1 is falling, 2 is any.
REQ-005 SHALL provide parameter SYNC_STAGES, default 2: number of input synchroniser flops, legal range 2..4.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: reset, which is synchronous and active-high.
REQ-008 SHALL have port address, input, 3 bits: Avalon-MM word address.
REQ-009 SHALL have port chipselect, input, 1 bit: slave select.
REQ-010 SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-011 SHALL have port writedata, input, 32 bits: write data.
REQ-012 SHALL have port readdata, output, 32 bits: read data, read latency 0.
REQ-013 SHALL have port in_port, input, IN_WIDTH bits: asynchronous external inputs, such as buttons.
REQ-014 SHALL have port out_port, output, OUT_WIDTH bits: output register value.
REQ-015 SHALL have port irq, output, 1 bit: active-high level interrupt.

Function
REQ-016 SHALL perform a write in a cycle only when chipselect=1 and write_n=0; the write takes effect at the next clock edge.
REQ-017 SHALL implement this register map: 0 DATA (RW), 1 INPUT (RO), 2 IRQ_MASK (RW, IN_WIDTH bits), 3 EDGE_CAPTURE (R, write-1-to-clear), 4 OUTSET (WO), 5 OUTCLEAR (WO); addresses 6-7 are reserved.
REQ-018 SHALL zero-extend readdata to 32 bits and derive it combinationally from address; reads SHALL have no side effects; reads of OUTSET, OUTCLEAR, addresses 6-7, and any unused upper bits SHALL return 0.
REQ-019 SHALL load writedata[OUT_WIDTH-1:0] into the output register on a DATA write and ignore the upper writedata bits.
REQ-020 SHALL compute, on an OUTSET write, out = out | writedata[OUT_WIDTH-1:0]; on an OUTCLEAR write, out = out & ~writedata[OUT_WIDTH-1:0].
REQ-021 SHALL drive out_port directly from the output register, so a write is visible on out_port one clock edge after the write cycle.
REQ-022 SHALL pass in_port through a SYNC_STAGES-deep flop chain; INPUT SHALL read the last stage (sync_in).
REQ-023 SHALL register sync_in into prev every cycle; per bit, edge = sync_in&~prev (EDGE_TYPE 0), ~sync_in&prev (EDGE_TYPE 1), or sync_in^prev (EDGE_TYPE 2).
REQ-024 SHALL suppress edge detection for SYNC_STAGES+1 cycles after reset deasserts (prime counter); edge detection is enabled from the following cycle on.
REQ-025 SHALL make each EDGE_CAPTURE bit sticky: it is set by a detected edge and cleared only by an EDGE_CAPTURE write with a 1 in that bit position.
REQ-026 SHALL give the edge priority when a clearing write and a new edge hit the same bit in the same cycle: the bit stays 1.
REQ-027 SHALL leave EDGE_CAPTURE bits unchanged when the corresponding writedata bit is 0; writedata bits at and above IN_WIDTH SHALL be ignored.
REQ-028 SHALL drive irq = OR-reduction of (EDGE_CAPTURE & IRQ_MASK), generated combinationally from registers, with no glitch path from writedata.
REQ-029 SHALL assert irq immediately when IRQ_MASK is written to a 1 over an already-set capture bit (next edge); masking SHALL not clear capture bits.
REQ-030 SHALL take no action on writes to addresses 1, 6 and 7.

Reset
REQ-031 SHALL, when reset=1 at a clock edge, set out to RESET_VALUE[OUT_WIDTH-1:0], IRQ_MASK to 0, EDGE_CAPTURE to 0, all synchroniser stages and prev to 0, and restart the prime counter.
REQ-032 SHALL give reset priority over any simultaneous write or edge; irq SHALL be 0 from the first edge with reset=1 until a masked capture occurs.
REQ-033 SHALL, when reset asserts mid-operation, discard pending captures; an input held constant through reset SHALL produce no capture.

Verification
REQ-034 SHALL be verified with a reset-then-read test: apply reset and read DATA -> 0x00000040; read IRQ_MASK -> 0; read EDGE_CAPTURE -> 0; irq -> 0.
REQ-035 SHALL be verified with an output set/clear test: write DATA=0xFFFF1234, then OUTSET 0x0003, then OUTCLEAR 0x0030 -> out_port reads 0x1234, then 0x1237, then 0x1207; reads of address 4 return 0.
REQ-036 SHALL be verified with a synchronised edge capture test (EDGE_TYPE 0): set IRQ_MASK=0x01 and drive in_port[0] 0->1 -> EDGE_CAPTURE=0x01 after SYNC_STAGES+1 cycles, with irq high in the same cycle; write EDGE_CAPTURE=0x01 -> irq low one edge later.
REQ-037 SHALL be verified with a clear/edge collision test: time an EDGE_CAPTURE clear write of 0x02 to coincide with a detected edge on bit 1 -> bit 1 remains 1.
REQ-038 SHALL be verified with a startup suppression test: hold in_port=0xFF through reset and release -> EDGE_CAPTURE stays 0 for 20 cycles.
REQ-039 SHALL be verified with a mid-operation reset test: with EDGE_CAPTURE=0x05, IRQ_MASK=0x05 and DATA=0x00AA, pulse reset for 1 cycle -> EDGE_CAPTURE=0, irq=0, out_port=0x0040.

Source files
------------

// File: rtl/qsys_system_pio_irq.sv
// rtl/qsys_system_pio_irq.sv - Avalon-MM parallel I/O block with output register, synchronised edge capture and level IRQ
//
// Purpose:
//   Memory-mapped PIO peripheral. A writable output register drives out_port.
//   Asynchronous in_port bits are synchronised and watched for edges. Detected
//   edges are captured in sticky bits. Captured bits that are also masked in
//   raise a level interrupt.
//
// Register map (word address):
//   0 DATA          RW  output register (OUT_WIDTH bits)
//   1 INPUT         RO  synchronised input (IN_WIDTH bits)
//   2 IRQ_MASK      RW  per-bit interrupt enable (IN_WIDTH bits)
//   3 EDGE_CAPTURE  R/W1C sticky edge flags (IN_WIDTH bits)
//   4 OUTSET        WO  out |= writedata
//   5 OUTCLEAR      WO  out &= ~writedata
//   6-7             reserved, read 0, writes ignored
//
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous, active-high
//   address     Avalon-MM word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    read data, zero-extended, combinational (latency 0)
//   in_port     asynchronous external inputs
//   out_port    output register value
//   irq         active-high level interrupt

module qsys_system_pio_irq #(
  parameter int OUT_WIDTH   = 16,
  parameter int RESET_VALUE = 64,
  parameter int IN_WIDTH    = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic [IN_WIDTH-1:0]  in_port,
  output logic [OUT_WIDTH-1:0] out_port,
  output logic                 irq
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_INPUT    = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam logic [31:0]          RESET_VEC = 32'(RESET_VALUE);
  localparam logic [OUT_WIDTH-1:0] RESET_OUT = RESET_VEC[OUT_WIDTH-1:0];

  // Number of post-reset cycles during which edge detection is held off.
  // This covers the synchroniser refill plus the prev register, so an input
  // held constant across reset never looks like an edge.
  localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES + 1);

  logic                 wr_en;
  logic [OUT_WIDTH-1:0] wdata_out;
  logic [IN_WIDTH-1:0]  wdata_in;

  logic [OUT_WIDTH-1:0] out_q;
  logic [IN_WIDTH-1:0]  irq_mask_q;
  logic [IN_WIDTH-1:0]  edge_cap_q;

  logic [IN_WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [IN_WIDTH-1:0]  sync_in;
  logic [IN_WIDTH-1:0]  prev_q;

  logic [2:0]           prime_cnt;
  logic                 primed;

  logic [IN_WIDTH-1:0]  raw_edge;
  logic [IN_WIDTH-1:0]  edge_det;
  logic [IN_WIDTH-1:0]  cap_clr;

  logic                 unused_wdata;

  assign wr_en     = chipselect & ~write_n;
  assign wdata_out = writedata[OUT_WIDTH-1:0];
  assign wdata_in  = writedata[IN_WIDTH-1:0];

  // Upper writedata bits are architecturally ignored.
  assign unused_wdata = ^writedata;

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= RESET_OUT;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:     out_q <= wdata_out;
        ADDR_OUTSET:   out_q <= out_q | wdata_out;
        ADDR_OUTCLEAR: out_q <= out_q & ~wdata_out;
        default:       out_q <= out_q;
      endcase
    end
  end

  assign out_port = out_q;

  // ---------------------------------------------------------------------------
  // Interrupt mask
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask_q <= '0;
    end else if (wr_en && (address == ADDR_IRQ_MASK)) begin
      irq_mask_q <= wdata_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Input synchroniser and previous-value register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_in;
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Prime counter: saturates at PRIME_LAST, detection enabled once saturated
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      prime_cnt <= 3'd0;
    end else if (!primed) begin
      prime_cnt <= prime_cnt + 3'd1;
    end
  end

  assign primed = (prime_cnt == PRIME_LAST);

  // ---------------------------------------------------------------------------
  // Edge detection and sticky capture
  // ---------------------------------------------------------------------------
  always_comb begin
    raw_edge = '0;
    case (EDGE_TYPE)
      0:       raw_edge = sync_in & ~prev_q;
      1:       raw_edge = ~sync_in & prev_q;
      default: raw_edge = sync_in ^ prev_q;
    endcase
  end

  assign edge_det = primed ? raw_edge : '0;
  assign cap_clr  = (wr_en && (address == ADDR_EDGE_CAP)) ? wdata_in : '0;

  // Clear is applied first and the new edge OR-ed in afterwards, so an edge
  // arriving in the same cycle as its clear survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cap_q <= '0;
    end else begin
      edge_cap_q <= (edge_cap_q & ~cap_clr) | edge_det;
    end
  end

  // Register-only path: writedata never reaches irq combinationally.
  assign irq = |(edge_cap_q & irq_mask_q);

  // ---------------------------------------------------------------------------
  // Read mux (no side effects)
  // ---------------------------------------------------------------------------
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:     readdata[OUT_WIDTH-1:0] = out_q;
      ADDR_INPUT:    readdata[IN_WIDTH-1:0]  = sync_in;
      ADDR_IRQ_MASK: readdata[IN_WIDTH-1:0]  = irq_mask_q;
      ADDR_EDGE_CAP: readdata[IN_WIDTH-1:0]  = edge_cap_q;
      default:       readdata = 32'd0;
    endcase
  end

endmodule
